d_mult_pipe: RTL and testbench
==============================

# d_mult_pipe

Pipelined 23×23-bit integer multiplier that feeds the Dilithium modular-reduction stage (q = 8380417). It accepts operand pairs under a valid/ready handshake and produces the full 48-bit product, zero-extended from 46 bits, three edges later. A user tag is carried alongside each product so downstream butterfly control can re-associate results. It also flags out-of-range operands (≥ q) with a sticky error bit.

## Interface
- TAG_W, 8, width of the sideband tag carried with each operand pair
- Q, 8380417, modulus used only for the operand range check
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- a  in  23  operand A
- b  in  23  operand B
- in_tag  in  TAG_W  sideband tag for this pair
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept this cycle
- product  out  48  a*b; bits [47:46] always 0
- out_tag  out  TAG_W  tag of the pair that produced `product`
- out_valid  out  1  product/out_tag valid
- out_ready  in  1  downstream accepts this cycle
- occupancy  out  2  number of valid entries in flight, 0..3
- range_err  out  1  sticky: some accepted operand was ≥ Q

## Operation
- Three register stages; each holds a valid bit and its tag:
  - S1: registers a, b, tag.
  - S2: splits into aL = a[11:0], aH = a[22:12], bL = b[11:0], bH = b[22:12]. Registers four partial products: LL (24 b), LH (23 b), HL (23 b), HH (22 b).
  - S3: product = (HH<<24) + ((LH+HL)<<12) + LL, computed at 48-bit width with no truncation. Registered as the output.
- Global advance enable: en = ~out_valid | out_ready.
  - in_ready = en, combinational, with no dependence on in_valid.
  - When en = 1, all stages shift by one. S1.valid takes (in_valid & in_ready). Bubbles propagate as invalid entries.
  - When en = 0, every stage holds data, tag and valid unchanged.
- Bubbles are not collapsed. A stall freezes the whole pipe even if S1 or S2 is empty.
- Transfer in: in_valid & in_ready on a rising edge. Transfer out: out_valid & out_ready on a rising edge.
- occupancy = S1.valid + S2.valid + S3.valid, registered.
  - It increments on transfer-in without transfer-out, decrements on the reverse, and is unchanged on both or neither.
  - It must always equal the popcount of the stage valid bits.
- range_err is set on any transfer-in with a ≥ Q or b ≥ Q. It is cleared only by rst. The multiply still proceeds and is not saturated.
- Data and tag registers of invalid stages are don't-care internally. However, product and out_tag are forced to 0 when out_valid = 0.

## Timing
- Reset (rst high at a rising edge): all valid bits 0, occupancy 0, range_err 0, product 0, out_tag 0, out_valid 0.
  - in_ready is 1 in the cycle after reset, because out_valid = 0.
  - Reset mid-operation discards all in-flight entries. A transfer-in on the reset edge is also discarded.
- Latency: a pair accepted at edge N is presented with out_valid = 1 in the cycle following edge N+2 (three edges, no stalls).
- Throughput: one pair per cycle while out_ready is held high.
- Backpressure: out_valid = 1 and out_ready = 0 drives in_ready low in the same cycle, combinationally. out_valid, product and out_tag must stay stable until the transfer-out.
- Simultaneous transfer-in and transfer-out at a full pipe is legal and keeps occupancy at 3.
- Order is strictly FIFO: tags emerge in acceptance order.

## Test plan
- Reset then a = 8380416, b = 8380416, tag 0x5A, out_ready = 1 → three edges later: product = 0x3FE004000000, out_tag = 0x5A, range_err = 0.
- a = 0x7FFFFF, b = 0x7FFFFF → product = 0x3FFFFF000001 and range_err = 1. range_err stays 1 until rst pulses, then reads 0.
- Streaming back-to-back, tags 1..20 with random operands and out_ready = 1 → one result per cycle, in order, each matching a reference multiply; occupancy stays 3 in steady state.
- Fill the pipe, then hold out_ready = 0 for 5 cycles → in_ready = 0 and product/out_tag stable throughout. Release → the three results drain in order, occupancy steps 3→2→1→0 with no new input.
- in_valid toggling 1,0,1,0 with out_ready = 1 → results appear with matching gaps; occupancy equals the valid-bit popcount every cycle.
- Assert rst with 3 entries in flight and out_ready = 0 → the next cycle has out_valid = 0, product = 0, occupancy = 0, in_ready = 1. No stale result ever appears afterwards.

Source files
------------

// File: rtl/d_mult_pipe_if.sv
// Handshake bundle for d_mult_pipe: operand input side and product output side.
// Latency: none (wires only).
// Backpressure: carried by in_ready (to producer) and out_ready (from consumer).
// Ports: a, b, in_tag, in_valid, in_ready (input side); product, out_tag, out_valid,
//        out_ready (output side); occupancy, range_err (status).
interface d_mult_pipe_if #(
    parameter int TAG_W = 8
);
    logic [22:0]      a;
    logic [22:0]      b;
    logic [TAG_W-1:0] in_tag;
    logic             in_valid;
    logic             in_ready;
    logic [47:0]      product;
    logic [TAG_W-1:0] out_tag;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       occupancy;
    logic             range_err;

    // Multiplier side.
    modport slave (
        input  a, b, in_tag, in_valid, out_ready,
        output in_ready, product, out_tag, out_valid, occupancy, range_err
    );

    // Producer/consumer side.
    modport master (
        output a, b, in_tag, in_valid, out_ready,
        input  in_ready, product, out_tag, out_valid, occupancy, range_err
    );
endinterface

// File: rtl/d_mult_pipe.sv
// 23x23 pipelined multiplier with tag sideband and sticky operand range check (>= Q).
// Latency: 3 edges from transfer-in to out_valid; one pair per cycle with out_ready high.
// Backpressure: out_valid & ~out_ready freezes every stage; in_ready drops combinationally.
// Ports: clk, rst (sync, active-high); bus (slave): a/b/in_tag/in_valid/in_ready in,
//        product/out_tag/out_valid/out_ready out, occupancy and range_err status.
module d_mult_pipe #(
    parameter int TAG_W = 8,
    parameter int Q     = 8380417
) (
    input  logic            clk,
    input  logic            rst,
    d_mult_pipe_if.slave    bus
);

    localparam logic [22:0] Q_L = 23'(Q);

    // Stage 1: raw operands.
    logic [22:0]      s1_a_q, s1_a_d;
    logic [22:0]      s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_vld_q, s1_vld_d;

    // Stage 2: four partial products of the 12/11-bit operand halves.
    logic [23:0]      s2_ll_q, s2_ll_d;
    logic [22:0]      s2_lh_q, s2_lh_d;
    logic [22:0]      s2_hl_q, s2_hl_d;
    logic [21:0]      s2_hh_q, s2_hh_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_vld_q, s2_vld_d;

    // Stage 3: recombined product, drives the output.
    logic [47:0]      s3_prod_q, s3_prod_d;
    logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
    logic             s3_vld_q, s3_vld_d;

    logic [1:0]       occ_q, occ_d;
    logic             rerr_q, rerr_d;

    logic             en;
    logic             xfer_in;
    logic             xfer_out;
    logic             oor;

    // Single advance enable for the whole pipe: bubbles are never collapsed.
    assign en       = ~s3_vld_q | bus.out_ready;
    assign xfer_in  = bus.in_valid & en;
    assign xfer_out = s3_vld_q & bus.out_ready;
    assign oor      = (bus.a >= Q_L) | (bus.b >= Q_L);

    always_comb begin
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_tag_d  = s1_tag_q;
        s1_vld_d  = s1_vld_q;
        s2_ll_d   = s2_ll_q;
        s2_lh_d   = s2_lh_q;
        s2_hl_d   = s2_hl_q;
        s2_hh_d   = s2_hh_q;
        s2_tag_d  = s2_tag_q;
        s2_vld_d  = s2_vld_q;
        s3_prod_d = s3_prod_q;
        s3_tag_d  = s3_tag_q;
        s3_vld_d  = s3_vld_q;

        if (en) begin
            s1_a_d    = bus.a;
            s1_b_d    = bus.b;
            s1_tag_d  = bus.in_tag;
            s1_vld_d  = xfer_in;

            s2_ll_d   = 24'(s1_a_q[11:0])  * 24'(s1_b_q[11:0]);
            s2_lh_d   = 23'(s1_a_q[11:0])  * 23'(s1_b_q[22:12]);
            s2_hl_d   = 23'(s1_a_q[22:12]) * 23'(s1_b_q[11:0]);
            s2_hh_d   = 22'(s1_a_q[22:12]) * 22'(s1_b_q[22:12]);
            s2_tag_d  = s1_tag_q;
            s2_vld_d  = s1_vld_q;

            // Cross terms are summed at full width before the shift so the carry is kept.
            s3_prod_d = (48'(s2_hh_q) << 24)
                      + ((48'(s2_lh_q) + 48'(s2_hl_q)) << 12)
                      + 48'(s2_ll_q);
            s3_tag_d  = s2_tag_q;
            s3_vld_d  = s2_vld_q;
        end
    end

    // Occupancy tracks transfers rather than a popcount; both agree because a stage
    // can only gain an entry via transfer-in and lose one via transfer-out.
    always_comb begin
        occ_d = occ_q;
        if (xfer_in & ~xfer_out) begin
            occ_d = occ_q + 2'd1;
        end else if (~xfer_in & xfer_out) begin
            occ_d = occ_q - 2'd1;
        end
    end

    assign rerr_d = rerr_q | (xfer_in & oor);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_tag_q  <= '0;
            s1_vld_q  <= 1'b0;
            s2_ll_q   <= '0;
            s2_lh_q   <= '0;
            s2_hl_q   <= '0;
            s2_hh_q   <= '0;
            s2_tag_q  <= '0;
            s2_vld_q  <= 1'b0;
            s3_prod_q <= '0;
            s3_tag_q  <= '0;
            s3_vld_q  <= 1'b0;
            occ_q     <= 2'd0;
            rerr_q    <= 1'b0;
        end else begin
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_tag_q  <= s1_tag_d;
            s1_vld_q  <= s1_vld_d;
            s2_ll_q   <= s2_ll_d;
            s2_lh_q   <= s2_lh_d;
            s2_hl_q   <= s2_hl_d;
            s2_hh_q   <= s2_hh_d;
            s2_tag_q  <= s2_tag_d;
            s2_vld_q  <= s2_vld_d;
            s3_prod_q <= s3_prod_d;
            s3_tag_q  <= s3_tag_d;
            s3_vld_q  <= s3_vld_d;
            occ_q     <= occ_d;
            rerr_q    <= rerr_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = s3_vld_q;
    // Stale data in an empty output stage is never exposed.
    assign bus.product   = s3_vld_q ? s3_prod_q : 48'd0;
    assign bus.out_tag   = s3_vld_q ? s3_tag_q : '0;
    assign bus.occupancy = occ_q;
    assign bus.range_err = rerr_q;

endmodule

// File: tb/tb_d_mult_pipe.sv
// Testbench for d_mult_pipe: directed vector table, hand sequences and random streaming.
// Latency: n/a.
// Backpressure: driven by the stimulus through out_ready.
module tb_d_mult_pipe;

    localparam int TAG_W = 8;
    localparam int Q     = 8380417;

    logic clk;
    logic rst;

    d_mult_pipe_if #(.TAG_W(TAG_W)) bus ();

    d_mult_pipe #(.TAG_W(TAG_W), .Q(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    bit mon_on   = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] mul(input logic [22:0] x, input logic [22:0] y);
        return 48'(x) * 48'(y);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: FIFO of accepted pairs, each aging one step per
    // pipeline advance; the head is visible once it has aged three steps.
    // ------------------------------------------------------------------
    logic [47:0]      m_prod[$];
    logic [TAG_W-1:0] m_tag[$];
    int               m_age[$];
    logic             m_rerr = 1'b0;
    logic             m_vld;
    logic             m_en;
    logic             m_in;

    always @(negedge clk) begin
        if (mon_on) begin
            m_vld = (m_age.size() > 0) && (m_age[0] >= 3);
            m_en  = !m_vld || bus.out_ready;
            check("mon_out_valid", 64'(bus.out_valid), 64'(m_vld));
            check("mon_occupancy", 64'(bus.occupancy), 64'(m_age.size()));
            check("mon_range_err", 64'(bus.range_err), 64'(m_rerr));
            check("mon_in_ready",  64'(bus.in_ready),  64'(m_en));
            if (m_vld) begin
                check("mon_product", 64'(bus.product), 64'(m_prod[0]));
                check("mon_out_tag", 64'(bus.out_tag), 64'(m_tag[0]));
            end else begin
                check("mon_product_idle", 64'(bus.product), 64'd0);
                check("mon_out_tag_idle", 64'(bus.out_tag), 64'd0);
            end
            if (bus.out_valid && bus.out_ready) n_out++;
            m_in = bus.in_valid && m_en;
            if (rst) begin
                m_prod.delete();
                m_tag.delete();
                m_age.delete();
                m_rerr = 1'b0;
            end else begin
                if (m_vld && bus.out_ready) begin
                    void'(m_prod.pop_front());
                    void'(m_tag.pop_front());
                    void'(m_age.pop_front());
                end
                if (m_en) begin
                    foreach (m_age[i]) m_age[i] = m_age[i] + 1;
                end
                if (m_in) begin
                    m_prod.push_back(mul(bus.a, bus.b));
                    m_tag.push_back(bus.in_tag);
                    m_age.push_back(1);
                    if (bus.a >= 23'(Q) || bus.b >= 23'(Q)) m_rerr = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({nm, "_product"},   64'(bus.product),   64'd0);
        check({nm, "_out_tag"},   64'(bus.out_tag),   64'd0);
        check({nm, "_occupancy"}, 64'(bus.occupancy), 64'd0);
        check({nm, "_range_err"}, 64'(bus.range_err), 64'd0);
        check({nm, "_in_ready"},  64'(bus.in_ready),  64'd1);
    endtask

    task automatic send(input logic [22:0] x, input logic [22:0] y, input logic [TAG_W-1:0] t);
        bus.a = x;
        bus.b = y;
        bus.in_tag = t;
        bus.in_valid = 1'b1;
    endtask

    typedef struct {
        logic [22:0]      a;
        logic [22:0]      b;
        logic [TAG_W-1:0] tag;
        logic [47:0]      prod;
        logic             err;
    } vec_t;

    vec_t tv[8];

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [47:0] p0;
        rst = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.in_tag = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;

        tv[0] = '{23'd8380416, 23'd8380416, 8'h5A, 48'h3FE004000000, 1'b0};
        tv[1] = '{23'h7FFFFF,  23'h7FFFFF,  8'hA5, 48'h3FFFFF000001, 1'b1};
        tv[2] = '{23'd0,       23'h7FFFFF,  8'h01, 48'h000000000000, 1'b1};
        tv[3] = '{23'd1,       23'd1,       8'h02, 48'h000000000001, 1'b0};
        tv[4] = '{23'd8380417, 23'd1,       8'h03, 48'h0000007FE001, 1'b1};
        tv[5] = '{23'd8380416, 23'd1,       8'h04, 48'h0000007FE000, 1'b0};
        tv[6] = '{23'h001000,  23'h001000,  8'h05, 48'h000001000000, 1'b0};
        tv[7] = '{23'h000FFF,  23'h7FF000,  8'h06, 48'h0007FE801000, 1'b1};

        do_reset();
        check_idle("reset");

        // Directed vectors: exact three-edge latency, value, tag, range flag.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            bus.out_ready = 1'b1;
            send(tv[i].a, tv[i].b, tv[i].tag);
            cyc();
            bus.in_valid = 1'b0;
            check("vec_lat_edge1", 64'(bus.out_valid), 64'd0);
            cyc();
            check("vec_lat_edge2", 64'(bus.out_valid), 64'd0);
            cyc();
            check("vec_out_valid", 64'(bus.out_valid), 64'd1);
            check("vec_product",   64'(bus.product),   64'(tv[i].prod));
            check("vec_out_tag",   64'(bus.out_tag),   64'(tv[i].tag));
            check("vec_range_err", 64'(bus.range_err), 64'(tv[i].err));
            cyc();
        end

        // Sticky range error survives in-range traffic, clears only on reset.
        do_reset();
        send(23'h7FFFFF, 23'h7FFFFF, 8'h10);
        cyc();
        for (int i = 0; i < 5; i++) begin
            send(23'(i + 3), 23'd7, 8'(8'h11 + i));
            cyc();
            check("rerr_sticky", 64'(bus.range_err), 64'd1);
        end
        bus.in_valid = 1'b0;
        do_reset();
        check("rerr_cleared", 64'(bus.range_err), 64'd0);

        // Back-to-back streaming, tags 1..20.
        do_reset();
        n_out = 0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            send(23'($urandom), 23'($urandom_range(0, Q - 1)), 8'(i));
            cyc();
            if (i >= 3) check("stream_occ", 64'(bus.occupancy), 64'd3);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("stream_count", 64'(n_out), 64'd20);

        // Fill, stall five cycles with a pending input, then drain.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(23'(1000 + i), 23'(77 * (i + 1)), 8'(8'h30 + i));
            cyc();
        end
        p0 = mul(23'd1000, 23'd77);
        send(23'd5, 23'd5, 8'hEE);
        bus.out_ready = 1'b0;
        #1;
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_valid",   64'(bus.out_valid), 64'd1);
            check("stall_product", 64'(bus.product),   64'(p0));
            check("stall_tag",     64'(bus.out_tag),   64'h30);
            check("stall_occ",     64'(bus.occupancy), 64'd3);
            check("stall_in_rdy",  64'(bus.in_ready),  64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("drain_occ", 64'(bus.occupancy), 64'(3 - d));
            check("drain_tag", 64'(bus.out_tag),   64'(8'h30 + d));
            cyc();
        end
        check("drain_occ_end",   64'(bus.occupancy), 64'd0);
        check("drain_valid_end", 64'(bus.out_valid), 64'd0);

        // Input bubbles reappear as output gaps.
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(23'(k * 3 + 1), 23'(k + 2), 8'(8'h40 + k));
            bus.in_valid = (k % 2 == 0) && (k < 6);
            cyc();
            check("gap_out_valid", 64'(bus.out_valid), 64'((k == 2) || (k == 4) || (k == 6)));
        end
        bus.in_valid = 1'b0;

        // Reset with a full, stalled pipe and a transfer-in on the reset edge.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(23'(200 + i), 23'(300 + i), 8'(8'h60 + i));
            cyc();
        end
        bus.out_ready = 1'b0;
        send(23'd9, 23'd9, 8'h6F);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_idle("midrst");
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("midrst_no_stale", 64'(bus.out_valid), 64'd0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
